// File: rtl/m68k_bus_target.sv
// Purpose: 68000 async-bus target; decodes a 64 KB window and serves a word-wide register bank.
// Latency: DTACK low after edge E4+WAIT_STATES (E0 = first edge sampling AS low); released 2 edges after AS_s sees high.
// Backpressure: DTACK is held low until the initiator negates AS; the initiator alone paces cycles.
module m68k_bus_target #(
  parameter logic [7:0]  BASE_ADDR   = 8'hE9,
  parameter int          ADDR_BITS   = 3,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] ID_VALUE    = 16'h0530
) (
  input  logic        CLK7M,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic [2:0]  FC,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW00,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        DTACK
);

  localparam int         NREG = 1 << ADDR_BITS;
  localparam logic [3:0] WS   = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_MISS, S_WAIT, S_XFER, S_ACK} state_t;

  // Strobe synchronizers (two flops each, idle high)
  logic as_meta_q, as_s_q, uds_meta_q, uds_s_q, lds_meta_q, lds_s_q;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   rw_q, rw_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   dtack_q, dtack_d;
  logic                   doe_q, doe_d;
  logic [15:0]            dout_q, dout_d;
  logic [15:0]            regs_q [1:NREG-1];
  logic [15:0]            regs_d [1:NREG-1];

  logic                   ds_act;
  logic                   hit;
  logic [15:0]            rdata;

  // Address bits between the register index and the window decode alias into the bank
  generate
    if (ADDR_BITS < 15) begin : g_alias
      logic unused_a;
      assign unused_a = ^A[15:ADDR_BITS+1];
    end
  endgenerate

  assign ds_act = ~uds_s_q | ~lds_s_q;
  assign hit    = ~as_s_q & ds_act & (A[23:16] == BASE_ADDR) & (FC != 3'b111);

  // Read mux: register 0 is the fixed ID word, the rest come from the bank
  always_comb begin
    rdata = ID_VALUE;
    for (int i = 1; i < NREG; i++) begin
      if (idx_q == ADDR_BITS'(i)) rdata = regs_q[i];
    end
  end

  // State, synchronizer and datapath registers
  always_ff @(posedge CLK7M) begin
    if (RESET) begin
      as_meta_q  <= 1'b1;
      as_s_q     <= 1'b1;
      uds_meta_q <= 1'b1;
      uds_s_q    <= 1'b1;
      lds_meta_q <= 1'b1;
      lds_s_q    <= 1'b1;
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rw_q       <= 1'b1;
      cnt_q      <= '0;
      dtack_q    <= 1'b1;
      doe_q      <= 1'b0;
      dout_q     <= '0;
      for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      as_meta_q  <= AS;
      as_s_q     <= as_meta_q;
      uds_meta_q <= UDS;
      uds_s_q    <= uds_meta_q;
      lds_meta_q <= LDS;
      lds_s_q    <= lds_meta_q;
      state_q    <= state_d;
      idx_q      <= idx_d;
      rw_q       <= rw_d;
      cnt_q      <= cnt_d;
      dtack_q    <= dtack_d;
      doe_q      <= doe_d;
      dout_q     <= dout_d;
      for (int i = 1; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Next-state logic; an AS negation aborts any cycle that has not yet been acked
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d = S_WAIT;
          idx_d   = A[ADDR_BITS:1];
          rw_d    = RW00;
          cnt_d   = WS;
        end else if (~as_s_q & ds_act) begin
          state_d = S_MISS;
        end
      end
      S_MISS: if (as_s_q) state_d = S_IDLE;
      S_WAIT: begin
        if (as_s_q)              state_d = S_IDLE;
        else if (cnt_q == 4'd0)  state_d = S_XFER;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      S_XFER: state_d = as_s_q ? S_IDLE : S_ACK;
      S_ACK:  if (as_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and register-bank updates; byte lanes follow the synchronized strobes
  always_comb begin
    dtack_d = dtack_q;
    doe_d   = doe_q;
    dout_d  = dout_q;
    regs_d  = regs_q;
    case (state_q)
      S_XFER: begin
        if (~as_s_q) begin
          dtack_d = 1'b0;
          if (rw_q) begin
            dout_d = rdata;
            doe_d  = 1'b1;
          end else begin
            for (int i = 1; i < NREG; i++) begin
              if (idx_q == ADDR_BITS'(i)) begin
                if (~uds_s_q) regs_d[i][15:8] = D_IN[15:8];
                if (~lds_s_q) regs_d[i][7:0]  = D_IN[7:0];
              end
            end
          end
        end
      end
      S_ACK: begin
        if (as_s_q) begin
          dtack_d = 1'b1;
          doe_d   = 1'b0;
        end
      end
      default: begin
        dtack_d = 1'b1;
        doe_d   = 1'b0;
      end
    endcase
  end

  assign DTACK = dtack_q;
  assign D_OE  = doe_q;
  assign D_OUT = dout_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Bench for m68k_bus_target: three instances (0, 3 and 4 wait states) share one bus.
// Driver pushes expected acks into a scoreboard; a negedge monitor pops on each DTACK fall.
// Window bases: E9 (0 WS), EA (3 WS), EB (4 WS).
module tb_m68k_bus_target;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:1] a;
  logic [2:0]  fc;
  logic        as_n, uds_n, lds_n, rw;
  logic [15:0] din;
  logic [15:0] dout0, dout1, dout2;
  logic [15:0] dout [3];
  logic [2:0]  doe, dtack;

  typedef struct {
    int          inst;
    logic        rd;
    logic [15:0] dat;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   t_start = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  m68k_bus_target #(.BASE_ADDR(8'hE9), .WAIT_STATES(0)) u0 (
    .CLK7M(clk), .RESET(rst), .A(a), .FC(fc), .AS(as_n), .UDS(uds_n), .LDS(lds_n),
    .RW00(rw), .D_IN(din), .D_OUT(dout0), .D_OE(doe[0]), .DTACK(dtack[0]));
  m68k_bus_target #(.BASE_ADDR(8'hEA), .WAIT_STATES(3)) u1 (
    .CLK7M(clk), .RESET(rst), .A(a), .FC(fc), .AS(as_n), .UDS(uds_n), .LDS(lds_n),
    .RW00(rw), .D_IN(din), .D_OUT(dout1), .D_OE(doe[1]), .DTACK(dtack[1]));
  m68k_bus_target #(.BASE_ADDR(8'hEB), .WAIT_STATES(4)) u2 (
    .CLK7M(clk), .RESET(rst), .A(a), .FC(fc), .AS(as_n), .UDS(uds_n), .LDS(lds_n),
    .RW00(rw), .D_IN(din), .D_OUT(dout2), .D_OE(doe[2]), .DTACK(dtack[2]));

  assign dout[0] = dout0;
  assign dout[1] = dout1;
  assign dout[2] = dout2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every falling DTACK must match the oldest expected ack
  logic [2:0] prev = 3'b111;
  exp_t       e;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (prev[i] && !dtack[i]) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_dtack inst=%0d actual=ack required=none", i);
        end else begin
          e = sbq.pop_front();
          check("ack_inst", i, e.inst);
          check("ack_latency", cyc - t_start, e.lat);
          check("ack_doe", {31'd0, doe[i]}, {31'd0, e.rd});
          if (e.rd) check("rd_data", {16'd0, dout[i]}, {16'd0, e.dat});
        end
      end
      prev[i] = dtack[i];
    end
  end

  // One full bus cycle; ack cycles drop strobes early and check the release timing
  task automatic bus_cycle(input logic [23:0] addr, input logic [2:0] f, input logic r,
                           input logic u, input logic l, input logic [15:0] d,
                           input int inst, input logic ack, input logic [15:0] edat,
                           input int lat);
    int   n;
    logic bad;
    if (ack) sbq.push_back('{inst: inst, rd: r, dat: edat, lat: lat});
    @(negedge clk);
    a = addr[23:1]; fc = f; rw = r; din = d; uds_n = u; lds_n = l; as_n = 1'b0;
    t_start = cyc;
    if (ack) begin
      n = 0;
      while (dtack[inst] !== 1'b0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        tests++;
        fails++;
        $display("FAIL ack_timeout inst=%0d actual=no_dtack required=dtack", inst);
      end
      @(negedge clk);
      uds_n = 1'b1; lds_n = 1'b1;
      repeat (3) @(negedge clk);
      check("hold_dtack_ds_off", {31'd0, dtack[inst]}, 32'd0);
      check("hold_doe", {31'd0, doe[inst]}, {31'd0, r});
      as_n = 1'b1;
      repeat (2) @(negedge clk);
      check("release_early_dtack", {31'd0, dtack[inst]}, 32'd0);
      repeat (2) @(negedge clk);
      check("release_dtack", {31'd0, dtack[inst]}, 32'd1);
      check("release_doe", {31'd0, doe[inst]}, 32'd0);
    end else begin
      bad = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (dtack !== 3'b111 || doe !== 3'b000) bad = 1'b1;
      end
      check("miss_no_response", {31'd0, bad}, 32'd0);
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ab;
    logic        bad;
    int          n;

    rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    fc = 3'b101; a = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dtack", {29'd0, dtack}, 32'h7);
    check("reset_doe", {29'd0, doe}, 32'h0);
    check("reset_dout", {16'd0, dout0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ID register, word write/read, top index
    bus_cycle(24'hE90000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0530, 5);
    bus_cycle(24'hE90004, 3'b101, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, 1'b1, 16'h0000, 5);
    bus_cycle(24'hE90004, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'hBEEF, 5);
    bus_cycle(24'hE9000E, 3'b101, 1'b0, 1'b0, 1'b0, 16'h5A5A, 0, 1'b1, 16'h0000, 5);
    bus_cycle(24'hE9000E, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h5A5A, 5);

    // Byte lanes on index 1
    bus_cycle(24'hE90002, 3'b101, 1'b0, 1'b0, 1'b0, 16'h1234, 0, 1'b1, 16'h0000, 5);
    bus_cycle(24'hE90002, 3'b101, 1'b0, 1'b1, 1'b0, 16'h55AB, 0, 1'b1, 16'h0000, 5);
    bus_cycle(24'hE90002, 3'b101, 1'b1, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 16'h12AB, 5);
    bus_cycle(24'hE90002, 3'b101, 1'b0, 1'b0, 1'b1, 16'hCD77, 0, 1'b1, 16'h0000, 5);
    bus_cycle(24'hE90002, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'hCDAB, 5);

    // Three wait states; index 0 ignores writes but still acks
    bus_cycle(24'hEA0000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0530, 8);
    bus_cycle(24'hEA0000, 3'b101, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1, 1'b1, 16'h0000, 8);
    bus_cycle(24'hEA0000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0530, 8);
    bus_cycle(24'hEA0004, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0000, 8);

    // Outside every window, then CPU space inside a window, then a normal cycle
    bus_cycle(24'hE80000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 0);
    bus_cycle(24'hE90004, 3'b111, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 0);
    bus_cycle(24'hE90004, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'hBEEF, 5);

    // Abort in WAIT on the four-wait-state target: no ack, register untouched
    ab = 24'hEB0002;
    @(negedge clk);
    a = ab[23:1]; fc = 3'b101; rw = 1'b0; din = 16'hDEAD;
    uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    repeat (2) @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    bad = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (dtack !== 3'b111) bad = 1'b1;
    end
    check("abort_no_dtack", {31'd0, bad}, 32'd0);
    bus_cycle(24'hEB0002, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b1, 16'h0000, 9);

    // Reset while in ACK releases DTACK on that edge
    ab = 24'hE90004;
    sbq.push_back('{inst: 0, rd: 1'b1, dat: 16'hBEEF, lat: 5});
    @(negedge clk);
    a = ab[23:1]; fc = 3'b101; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    t_start = cyc;
    n = 0;
    while (dtack[0] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reset_ack_reached", {31'd0, dtack[0]}, 32'd0);
    rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk);
    check("reset_in_ack_dtack", {31'd0, dtack[0]}, 32'd1);
    check("reset_in_ack_doe", {31'd0, doe[0]}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Bank cleared by reset, ID still fixed
    bus_cycle(24'hE90004, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, 5);
    bus_cycle(24'hE90000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0530, 5);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
